// File: rtl/spike_row_accumulator.sv
// spike_row_accumulator: sums a fixed number of valid popcount beats into one
// row sum and queues finished rows in a 2-entry valid/ready output buffer.
// The upstream is never stalled; a row completing into a full, non-draining
// buffer is dropped and flagged on the sticky o_Overflow.
// Optional feature macro: ACC_SATURATE_EN (clamp the row adder at all-ones
// instead of wrapping).
module spike_row_accumulator #(
    parameter int unsigned SUM_WIDTH = 5,
    parameter int unsigned ROW_BEATS = 16,
    parameter int unsigned ACC_WIDTH = 10,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                 s_clk,
    input  logic                 s_rst,
    input  logic [SUM_WIDTH-1:0] i_SpikeSum,
    input  logic                 i_SpikeSum_valid,
    input  logic                 i_Clear,
    output logic [ACC_WIDTH-1:0] o_RowSum,
    output logic [TAG_WIDTH-1:0] o_RowTag,
    output logic                 o_RowSum_valid,
    input  logic                 i_RowSum_ready,
    output logic                 o_Overflow,
    output logic                 o_Busy
);

    localparam int unsigned CNT_WIDTH = $clog2(ROW_BEATS);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(ROW_BEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc, acc_nxt;
    logic [CNT_WIDTH-1:0] count, count_nxt;
    logic [TAG_WIDTH-1:0] tag, tag_nxt;
    logic [ACC_WIDTH-1:0] beat_ext;
    logic [ACC_WIDTH-1:0] acc_add;
    logic                 push;

    logic [ACC_WIDTH-1:0] sum_mem [2];
    logic [TAG_WIDTH-1:0] tag_mem [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           occ;
    logic                 pop;
    logic                 wr_en;
    logic                 overflow_set;

    assign beat_ext = ACC_WIDTH'(i_SpikeSum);

`ifdef ACC_SATURATE_EN
    logic [ACC_WIDTH:0] sum_full;
    assign sum_full = {1'b0, acc} + {1'b0, beat_ext};
    // Carry out means the row exceeded the range; pin it at all-ones.
    assign acc_add  = sum_full[ACC_WIDTH] ? '1 : sum_full[ACC_WIDTH-1:0];
`else
    assign acc_add  = acc + beat_ext;
`endif

    // Next-state and datapath updates; clear overrides any same-cycle beat.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        tag_nxt   = tag;
        push      = 1'b0;
        if (i_Clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            count_nxt = '0;
        end else if (i_SpikeSum_valid) begin
            case (state)
                IDLE: begin
                    state_nxt = ACCUM;
                    acc_nxt   = beat_ext;
                    count_nxt = CNT_WIDTH'(1);
                end
                ACCUM: begin
                    if (count == LAST_BEAT) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                        count_nxt = '0;
                        tag_nxt   = tag + TAG_WIDTH'(1);
                    end else begin
                        acc_nxt   = acc_add;
                        count_nxt = count + CNT_WIDTH'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Row state register: FSM state, partial sum, beat count and next tag.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            tag   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            tag   <= tag_nxt;
        end
    end

    // A pop frees the head slot at the same edge, so a full buffer can still
    // accept a push when it is being drained.
    assign pop          = o_RowSum_valid && i_RowSum_ready;
    assign wr_en        = push && ((occ != 2'd2) || pop);
    assign overflow_set = push && (occ == 2'd2) && !pop;

    // Output buffer storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            sum_mem[0] <= '0;
            sum_mem[1] <= '0;
            tag_mem[0] <= '0;
            tag_mem[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            occ        <= 2'd0;
            o_Overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                sum_mem[wr_ptr] <= acc_add;
                tag_mem[wr_ptr] <= tag;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_en, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (overflow_set) begin
                o_Overflow <= 1'b1;
            end
        end
    end

    assign o_RowSum       = sum_mem[rd_ptr];
    assign o_RowTag       = tag_mem[rd_ptr];
    assign o_RowSum_valid = (occ != 2'd0);
    assign o_Busy         = (state == ACCUM);

endmodule

// File: tb/tb_spike_row_accumulator.sv
// Directed bench for spike_row_accumulator. A second instance with an 8-bit
// accumulator shares all inputs and is checked only where its width matters.
module tb_spike_row_accumulator;

    logic        s_clk;
    logic        s_rst;
    logic [5:0]  i_SpikeSum;
    logic        i_SpikeSum_valid;
    logic        i_Clear;
    logic        i_RowSum_ready;

    logic [9:0]  o_RowSum;
    logic [7:0]  o_RowTag;
    logic        o_RowSum_valid;
    logic        o_Overflow;
    logic        o_Busy;

    logic [7:0]  n_RowSum;
    logic [7:0]  n_RowTag;
    logic        n_RowSum_valid;
    logic        n_Overflow;
    logic        n_Busy;

    int errors = 0;
    int checks = 0;

    spike_row_accumulator #(
        .SUM_WIDTH(6),
        .ROW_BEATS(16),
        .ACC_WIDTH(10),
        .TAG_WIDTH(8)
    ) dut (
        .s_clk           (s_clk),
        .s_rst           (s_rst),
        .i_SpikeSum      (i_SpikeSum),
        .i_SpikeSum_valid(i_SpikeSum_valid),
        .i_Clear         (i_Clear),
        .o_RowSum        (o_RowSum),
        .o_RowTag        (o_RowTag),
        .o_RowSum_valid  (o_RowSum_valid),
        .i_RowSum_ready  (i_RowSum_ready),
        .o_Overflow      (o_Overflow),
        .o_Busy          (o_Busy)
    );

    spike_row_accumulator #(
        .SUM_WIDTH(6),
        .ROW_BEATS(16),
        .ACC_WIDTH(8),
        .TAG_WIDTH(8)
    ) dut8 (
        .s_clk           (s_clk),
        .s_rst           (s_rst),
        .i_SpikeSum      (i_SpikeSum),
        .i_SpikeSum_valid(i_SpikeSum_valid),
        .i_Clear         (i_Clear),
        .o_RowSum        (n_RowSum),
        .o_RowTag        (n_RowTag),
        .o_RowSum_valid  (n_RowSum_valid),
        .i_RowSum_ready  (i_RowSum_ready),
        .o_Overflow      (n_Overflow),
        .o_Busy          (n_Busy)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int v);
        i_SpikeSum       = 6'(v);
        i_SpikeSum_valid = 1'b1;
        step();
        i_SpikeSum_valid = 1'b0;
    endtask

    task automatic send_n(input int v, input int n);
        for (int k = 0; k < n; k++) send(v);
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        step();
        step();
        s_rst = 1'b0;
    endtask

    initial begin
        s_rst            = 1'b1;
        i_SpikeSum       = '0;
        i_SpikeSum_valid = 1'b0;
        i_Clear          = 1'b0;
        i_RowSum_ready   = 1'b1;

        // Reset values
        step();
        step();
        chk("rst_valid",   32'(o_RowSum_valid), 0);
        chk("rst_sum",     32'(o_RowSum), 0);
        chk("rst_tag",     32'(o_RowTag), 0);
        chk("rst_ovf",     32'(o_Overflow), 0);
        chk("rst_busy",    32'(o_Busy), 0);
        chk("rst8_valid",  32'(n_RowSum_valid), 0);
        chk("rst8_sum",    32'(n_RowSum), 0);
        chk("rst8_tag",    32'(n_RowTag), 0);
        chk("rst8_ovf",    32'(n_Overflow), 0);
        chk("rst8_busy",   32'(n_Busy), 0);
        s_rst = 1'b0;

        // 16 contiguous beats of 3 -> 48, tag 0, one cycle after last beat
        send(3);
        chk("t1_busy_first", 32'(o_Busy), 1);
        send_n(3, 14);
        chk("t1_not_early", 32'(o_RowSum_valid), 0);
        send(3);
        chk("t1_valid", 32'(o_RowSum_valid), 1);
        chk("t1_sum",   32'(o_RowSum), 48);
        chk("t1_tag",   32'(o_RowTag), 0);
        chk("t1_busy",  32'(o_Busy), 0);
        step();
        chk("t1_popped", 32'(o_RowSum_valid), 0);

        // 32 beats of 32 with gaps -> two rows of 512, tags 0 and 1
        do_reset();
        for (int i = 0; i < 32; i++) begin
            send(32);
            if (i == 15) begin
                chk("t2_r0_valid", 32'(o_RowSum_valid), 1);
                chk("t2_r0_sum",   32'(o_RowSum), 512);
                chk("t2_r0_tag",   32'(o_RowTag), 0);
            end
            if (i == 16) chk("t2_no_dup", 32'(o_RowSum_valid), 0);
            if (i == 31) begin
                chk("t2_r1_valid", 32'(o_RowSum_valid), 1);
                chk("t2_r1_sum",   32'(o_RowSum), 512);
                chk("t2_r1_tag",   32'(o_RowTag), 1);
                chk("t2_busy",     32'(o_Busy), 0);
            end
            if ((i % 3) == 1) step();
        end
        step();

        // Three rows with ready low -> 16 and 32 held, third row dropped
        do_reset();
        i_RowSum_ready = 1'b0;
        send_n(1, 16);
        chk("t3_r0_sum", 32'(o_RowSum), 16);
        chk("t3_r0_tag", 32'(o_RowTag), 0);
        send_n(2, 16);
        chk("t3_hold_sum", 32'(o_RowSum), 16);
        chk("t3_hold_tag", 32'(o_RowTag), 0);
        chk("t3_ovf_pre",  32'(o_Overflow), 0);
        send_n(3, 16);
        chk("t3_ovf",      32'(o_Overflow), 1);
        chk("t3_head_sum", 32'(o_RowSum), 16);
        chk("t3_head_tag", 32'(o_RowTag), 0);
        i_RowSum_ready = 1'b1;
        step();
        chk("t3_second_valid", 32'(o_RowSum_valid), 1);
        chk("t3_second_sum",   32'(o_RowSum), 32);
        chk("t3_second_tag",   32'(o_RowTag), 1);
        step();
        chk("t3_empty", 32'(o_RowSum_valid), 0);
        chk("t3_ovf_sticky", 32'(o_Overflow), 1);
        send_n(1, 16);
        chk("t3_next_sum", 32'(o_RowSum), 16);
        chk("t3_next_tag", 32'(o_RowTag), 3);
        step();

        // Clear mid-row discards the partial row and the same-cycle beat
        do_reset();
        send_n(7, 5);
        chk("t4_busy_pre", 32'(o_Busy), 1);
        i_Clear          = 1'b1;
        i_SpikeSum       = 6'd9;
        i_SpikeSum_valid = 1'b1;
        step();
        i_Clear          = 1'b0;
        i_SpikeSum_valid = 1'b0;
        chk("t4_busy_clr", 32'(o_Busy), 0);
        chk("t4_no_row",   32'(o_RowSum_valid), 0);
        send_n(1, 16);
        chk("t4_valid", 32'(o_RowSum_valid), 1);
        chk("t4_sum",   32'(o_RowSum), 16);
        chk("t4_tag",   32'(o_RowTag), 0);
        step();

        // Full buffer, push and pop on the same edge
        do_reset();
        i_RowSum_ready = 1'b0;
        send_n(4, 16);
        send_n(4, 16);
        send_n(5, 15);
        i_RowSum_ready = 1'b1;
        send(5);
        chk("t5_ovf",        32'(o_Overflow), 0);
        chk("t5_head_sum",   32'(o_RowSum), 64);
        chk("t5_head_tag",   32'(o_RowTag), 1);
        step();
        chk("t5_third_valid", 32'(o_RowSum_valid), 1);
        chk("t5_third_sum",   32'(o_RowSum), 80);
        chk("t5_third_tag",   32'(o_RowTag), 2);
        step();
        chk("t5_empty", 32'(o_RowSum_valid), 0);

        // 16 beats of 20: 320 at 10 bits; 8 bits wraps or clamps
        do_reset();
        send_n(20, 16);
        chk("t6_sum10", 32'(o_RowSum), 320);
`ifdef ACC_SATURATE_EN
        chk("t6_sum8",  32'(n_RowSum), 255);
`else
        chk("t6_sum8",  32'(n_RowSum), 64);
`endif
        chk("t6_valid8", 32'(n_RowSum_valid), 1);
        step();

        // Asynchronous reset mid-row with a full, overflowed buffer
        do_reset();
        i_RowSum_ready = 1'b0;
        send_n(1, 48);
        send_n(2, 5);
        chk("t7_pre_ovf",  32'(o_Overflow), 1);
        chk("t7_pre_busy", 32'(o_Busy), 1);
        #2;
        s_rst = 1'b1;
        #1;
        chk("t7_async_valid", 32'(o_RowSum_valid), 0);
        chk("t7_async_sum",   32'(o_RowSum), 0);
        chk("t7_async_tag",   32'(o_RowTag), 0);
        chk("t7_async_ovf",   32'(o_Overflow), 0);
        chk("t7_async_busy",  32'(o_Busy), 0);
        step();
        s_rst = 1'b0;
        i_RowSum_ready = 1'b1;
        send_n(2, 16);
        chk("t7_after_valid", 32'(o_RowSum_valid), 1);
        chk("t7_after_sum",   32'(o_RowSum), 32);
        chk("t7_after_tag",   32'(o_RowTag), 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
